// File: rtl/pc_ret_stack_if.sv
// Control strobes in, PC / return-stack status out, between control unit and PC block.
interface pc_ret_stack_if #(
  parameter int unsigned PC_WIDTH = 10
);
  logic [PC_WIDTH-1:0] d_in;
  logic                pc_ld;
  logic                pc_inc;
  logic                push;
  logic                pop;
  logic                clr_err;
  logic [PC_WIDTH-1:0] pc_count;
  logic [PC_WIDTH-1:0] from_stack;
  logic                empty;
  logic                full;
  logic                ovf_err;
  logic                unf_err;

  modport master (
    output d_in, pc_ld, pc_inc, push, pop, clr_err,
    input  pc_count, from_stack, empty, full, ovf_err, unf_err
  );

  modport slave (
    input  d_in, pc_ld, pc_inc, push, pop, clr_err,
    output pc_count, from_stack, empty, full, ovf_err, unf_err
  );
endinterface

// File: rtl/pc_ret_stack.sv
// Program counter with a hardware return-address stack feeding the PC-source mux.
module pc_ret_stack #(
  parameter int unsigned PC_WIDTH    = 10,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  pc_ret_stack_if.slave bus
);

  localparam int unsigned PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STACK_DEPTH);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] ret_addr;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                empty_q, empty_d;
  logic                full_q, full_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                ovf_evt, unf_evt;
  logic                wr_en;
  logic [PTR_W-1:0]    wr_idx;
  logic [PTR_W-1:0]    top_idx;
  logic [PC_WIDTH-1:0] mem_q [STACK_DEPTH];

  // Return address always comes from the pre-edge PC, even when a load happens alongside.
  assign ret_addr = pc_q + PC_WIDTH'(1);
  assign top_idx  = PTR_W'(count_q - CNT_W'(1));

  // Next PC: load beats increment beats hold; increment wraps naturally.
  always_comb begin
    pc_d = pc_q;
    if (bus.pc_ld) begin
      pc_d = bus.d_in;
    end else if (bus.pc_inc) begin
      pc_d = pc_q + PC_WIDTH'(1);
    end
  end

  // Stack occupancy, write port and error events; push+pop on a non-empty stack rewrites the top.
  always_comb begin
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = PTR_W'(count_q);
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    if (bus.push && bus.pop && !empty_q) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (bus.push) begin
      if (!full_q) begin
        wr_en   = 1'b1;
        count_d = count_q + CNT_W'(1);
      end else begin
        ovf_evt = 1'b1;
      end
    end else if (bus.pop) begin
      if (!empty_q) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        unf_evt = 1'b1;
      end
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_FULL);
    ovf_d   = (ovf_q & ~bus.clr_err) | ovf_evt;
    unf_d   = (unf_q & ~bus.clr_err) | unf_evt;
  end

  // Control/status state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Return-address storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= ret_addr;
    end
  end

  assign bus.pc_count   = pc_q;
  assign bus.from_stack = empty_q ? '0 : mem_q[top_idx];
  assign bus.empty      = empty_q;
  assign bus.full       = full_q;
  assign bus.ovf_err    = ovf_q;
  assign bus.unf_err    = unf_q;

endmodule

// File: doc/pc_ret_stack.md
Name: pc_ret_stack

Overview:
- Program-counter register plus hardware return-address stack.
- Sits directly downstream of the 4-way PC-source mux: it registers the mux output as the next PC.
- Also produces FROM_STACK, the mux's return-address input, which closes the CALL/RET loop.
- Control strobes come from the control-unit FSM; PC_COUNT drives the instruction memory address.

Parameters:
PC_WIDTH, 10, width of program counter and stack entries
STACK_DEPTH, 8, number of return-address entries (power of 2, >=2)

Ports:
CLK  in  1  system clock, all state updates on rising edge
RST_N  in  1  asynchronous active-low reset
D_IN  in  PC_WIDTH  next-PC value from the 4-way PC-source mux
PC_LD  in  1  load D_IN into PC
PC_INC  in  1  increment PC
PUSH  in  1  push return address (PC_COUNT+1) onto stack (CALL, interrupt entry)
POP  in  1  pop top of stack (RET/RETIE)
CLR_ERR  in  1  synchronous clear of sticky error flags
PC_COUNT  out  PC_WIDTH  current program counter
FROM_STACK  out  PC_WIDTH  top-of-stack value to mux input
EMPTY  out  1  stack holds 0 entries
FULL  out  1  stack holds STACK_DEPTH entries
OVF_ERR  out  1  sticky: PUSH attempted while FULL
UNF_ERR  out  1  sticky: POP attempted while EMPTY

Behaviour:
- Reset (RST_N low, asynchronous, any time incl. mid-operation):
  - PC_COUNT=0, count=0, EMPTY=1, FULL=0, OVF_ERR=0, UNF_ERR=0, FROM_STACK=0.
  - Stack storage is not reset; its contents are don't-care.
- PC update, one cycle latency (new value visible after the edge):
  - Priority is PC_LD > PC_INC > hold.
  - PC_INC wraps modulo 2^PC_WIDTH (3FF -> 000).
- Return address captured by PUSH is PC_COUNT+1 (mod 2^PC_WIDTH), taken from the pre-edge PC_COUNT. This holds even when PC_LD is asserted in the same cycle (the CALL case).
- FROM_STACK: combinational top entry when count>0; 0 when EMPTY.
  - Valid in the same cycle POP is asserted, so the mux can route it into D_IN with PC_LD in the same cycle (the RET case).
- Stack state is a count 0..STACK_DEPTH; EMPTY=(count==0), FULL=(count==STACK_DEPTH).
- PUSH only:
  - not FULL: write entry, count+1.
  - FULL: no write, count unchanged, OVF_ERR<=1.
- POP only:
  - not EMPTY: count-1.
  - EMPTY: count unchanged, UNF_ERR<=1.
- PUSH and POP in the same cycle:
  - not EMPTY: top entry replaced with PC_COUNT+1, count unchanged, no error flag.
  - EMPTY: behaves as PUSH only.
- Error flags:
  - Sticky until CLR_ERR or reset.
  - If CLR_ERR and a new error event occur in the same cycle, the flag is set (set wins).
- Stack strobes and PC strobes are independent and may all be asserted in one cycle.

Test Plan:
1. Reset then 3 cycles PC_INC=1 -> PC_COUNT 000,001,002,003; assert RST_N low mid-cycle -> PC_COUNT=0 immediately, EMPTY=1.
2. PC_LD=1 with D_IN=3FE, then PC_INC for 2 cycles -> 3FE, 3FF, 000 (wrap); PC_LD and PC_INC together with D_IN=055 -> 055.
3. CALL: PC=010, PUSH=1, PC_LD=1, D_IN=200 -> PC=200, FROM_STACK=011, EMPTY=0. RET: POP=1, PC_LD=1, D_IN=FROM_STACK -> PC=011, EMPTY=1, FROM_STACK=0.
4. 8 pushes from PC=000..007 -> FULL=1, FROM_STACK=008. 9th push -> OVF_ERR=1, FROM_STACK still 008. Pop 8 times -> returns 008 down to 001, then EMPTY=1.
5. POP on empty stack -> UNF_ERR=1, count stays 0. CLR_ERR=1 -> flag 0 next cycle. CLR_ERR with simultaneous underflow -> UNF_ERR stays 1.
6. With 2 entries (top=005) and PC=030: PUSH+POP together -> top=031, count still 2, no error flags. On an empty stack, PUSH+POP together -> count=1.
